sdram_arbiter: RTL and testbench
================================

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter MAX_STREAK, default 8: max consecutive port-0 grants while port 1 is waiting.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 16: cycles in ISSUE without Mem_Ack before error.
REQ-003 SHALL have port Clk, input, 1 bit: 100 MHz clock; all logic on the rising edge.
REQ-004 SHALL have port Reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports Req0/Req1, input, 1 bit each: request from port 0 (ADC capture writer) and port 1 (readout).
REQ-006 SHALL have ports WnR0/WnR1, input, 1 bit each: 1 = write, 0 = read.
REQ-007 SHALL have ports Addr0/Addr1, input, 22 bits each: SDRAM word address.
REQ-008 SHALL have ports WData0/WData1, input, 16 bits each: write data.
REQ-009 SHALL have ports Gnt0/Gnt1, output, 1 bit each: one-cycle pulse; request captured.
REQ-010 SHALL have ports Done0/Done1, output, 1 bit each: one-cycle pulse; granted transfer complete.
REQ-011 SHALL have ports Mem_Req, Mem_WnR, output, 1 bit each; Mem_Address, output, 22 bits; Mem_WData, output, 16 bits: to SDRAM interface.
REQ-012 SHALL have ports Mem_Busy, Mem_Ack, input, 1 bit each: from SDRAM interface.
REQ-013 SHALL have port Busy, output, 1 bit: state != IDLE.
REQ-014 SHALL have port Err, output, 1 bit: sticky timeout flag.

Function
REQ-015 SHALL implement states IDLE, ISSUE, WAIT_DONE.
REQ-016 IDLE -> ISSUE SHALL occur when Mem_Busy=0 and (Req0 or Req1); otherwise IDLE is held.
REQ-017 On IDLE -> ISSUE, the arbiter SHALL register the winner's WnR/Addr/WData into Mem_WnR/Mem_Address/Mem_WData, record the winner index, and pulse that port's Gnt in the same clock edge.
REQ-018 Winner selection: port 0 when only Req0 is high; port 1 when only Req1 is high; when both are high, port 0 wins unless streak==MAX_STREAK, in which case port 1 wins.
REQ-019 streak SHALL increment on each port-0 grant made while Req1 is high, saturating at MAX_STREAK, and SHALL clear on any port-1 grant or any cycle in IDLE with Req1 low.
REQ-020 Mem_Req SHALL be 1 throughout ISSUE and 0 in every other state.
REQ-021 ISSUE -> WAIT_DONE SHALL occur on the cycle Mem_Ack=1 is sampled.
REQ-022 In ISSUE, a counter SHALL count cycles from 0; when it reaches ACK_TIMEOUT, the arbiter SHALL set Err=1, go to IDLE, and pulse no Done.
REQ-023 WAIT_DONE -> IDLE SHALL occur on the first cycle Mem_Busy=0, pulsing Done of the recorded winner for exactly one cycle.
REQ-024 A new grant SHALL NOT be made in the cycle Done pulses; the earliest next grant is one cycle later.
REQ-025 A requester SHALL hold Req/WnR/Addr/WData stable until Gnt; values after Gnt are ignored for that transfer.
REQ-026 Mem_WnR/Mem_Address/Mem_WData SHALL remain stable from grant until leaving WAIT_DONE.
REQ-027 Gnt0 and Gnt1 SHALL never be high together; the same applies to Done0 and Done1.
REQ-028 Err SHALL be cleared only by reset.

Reset
REQ-029 Reset_n=0 SHALL asynchronously force state=IDLE, Mem_Req=0, Mem_WnR=0, Mem_Address=0, Mem_WData=0, Gnt*=0, Done*=0, Err=0, streak=0, timeout counter=0.
REQ-030 Reset mid-transfer SHALL abandon the transfer with no Done pulse; the first grant is possible on the second rising edge after Reset_n rises.

Structure
REQ-031 State encodings, default MAX_STREAK, ACK_TIMEOUT and the 22/16-bit width constants SHALL live in shared package sdram_pkg.
REQ-032 Winner selection plus streak counter SHALL be sub-module sdram_arb_select; the rest stays flat.

Verification
REQ-033 Req0 alone, Addr0=22'h00_0010, WnR0=1 -> next cycle Gnt0=1 and Mem_Address=22'h00_0010; Mem_Req held until Mem_Ack; Done0 one cycle after Mem_Busy falls.
REQ-034 Req0 and Req1 rise in the same cycle -> Gnt0 first; Gnt1 follows Done0 by at least one cycle.
REQ-035 Req0 continuously high and Req1 high, MAX_STREAK=8 -> exactly 8 Gnt0 pulses, then Gnt1, then Gnt0 resumes.
REQ-036 Mem_Ack held 0 after grant -> Err=1 after 16 cycles in ISSUE, state IDLE, no Done; Err stays 1 until Reset_n=0.
REQ-037 Reset_n pulsed low while in WAIT_DONE -> all outputs 0 immediately; no Done pulse.
REQ-038 Mem_Busy=1 held in IDLE with Req1 high -> no Gnt1 until Mem_Busy=0, then Gnt1 on the next edge.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared types and constants for the SDRAM two-port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package sdram_pkg;

  localparam int ADDR_W          = 22;
  localparam int DATA_W          = 16;
  localparam int DEF_MAX_STREAK  = 8;
  localparam int DEF_ACK_TIMEOUT = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_t;

  // One SDRAM command as captured from a requester at grant time.
  typedef struct packed {
    logic              wnr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/sdram_arb_select.sv
// Winner selection between port 0 and port 1 with a port-0 streak limiter.
// Latency: win1 is combinational from the requests and the streak register.
// Backpressure: none; the streak only advances when grant_en is asserted.
// Ports: Clk/Reset_n clock and async reset; req0/req1 requests; idle = arbiter
//        in IDLE; grant_en = a grant is taken this cycle; win1 = port 1 wins.
module sdram_arb_select #(
  parameter int MAX_STREAK = 8
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic req0,
  input  logic req1,
  input  logic idle,
  input  logic grant_en,
  output logic win1
);

  localparam int SW = $clog2(MAX_STREAK + 1);

  logic [SW-1:0] streak;
  logic          streak_full;

  assign streak_full = (streak == SW'(MAX_STREAK));

  // Port 0 has priority unless it has starved a waiting port 1 long enough.
  assign win1 = req1 && (!req0 || streak_full);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      streak <= '0;
    end else if (grant_en && win1) begin
      streak <= '0;
    end else if (grant_en && req1) begin
      // Port-0 grant while port 1 waits: count it, saturating.
      if (!streak_full) streak <= streak + SW'(1);
    end else if (idle && !req1) begin
      streak <= '0;
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Two-port SDRAM arbiter: grants one requester, issues its command, waits for done.
// Latency: Gnt one edge after an eligible request in IDLE; Done one edge after Mem_Busy drops.
// Backpressure: no grant while Mem_Busy is high or a transfer is in flight; ISSUE times out to Err.
// Ports: Req*/WnR*/Addr*/WData* from the two requesters, Gnt*/Done* pulses back;
//        Mem_* to/from the SDRAM interface; Busy = not IDLE; Err = sticky timeout.
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int MAX_STREAK  = DEF_MAX_STREAK,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Req0,
  input  logic              Req1,
  input  logic              WnR0,
  input  logic              WnR1,
  input  logic [ADDR_W-1:0] Addr0,
  input  logic [ADDR_W-1:0] Addr1,
  input  logic [DATA_W-1:0] WData0,
  input  logic [DATA_W-1:0] WData1,
  output logic              Gnt0,
  output logic              Gnt1,
  output logic              Done0,
  output logic              Done1,
  output logic              Mem_Req,
  output logic              Mem_WnR,
  output logic [ADDR_W-1:0] Mem_Address,
  output logic [DATA_W-1:0] Mem_WData,
  input  logic              Mem_Busy,
  input  logic              Mem_Ack,
  output logic              Busy,
  output logic              Err
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  state_t        state;
  logic [TW-1:0] tmo_cnt;
  logic          armed;     // low for the first edge after reset release
  logic          win_q;     // recorded winner: 1 = port 1
  logic          win1;
  logic          grant_en;
  mem_cmd_t      cmd0, cmd1, cmd_win, cmd_q;

  assign cmd0    = {WnR0, Addr0, WData0};
  assign cmd1    = {WnR1, Addr1, WData1};
  assign cmd_win = win1 ? cmd1 : cmd0;

  assign grant_en = (state == ST_IDLE) && armed && !Mem_Busy && (Req0 || Req1);

  sdram_arb_select #(
    .MAX_STREAK(MAX_STREAK)
  ) u_select (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .req0     (Req0),
    .req1     (Req1),
    .idle     (state == ST_IDLE),
    .grant_en (grant_en),
    .win1     (win1)
  );

  assign Mem_WnR     = cmd_q.wnr;
  assign Mem_Address = cmd_q.addr;
  assign Mem_WData   = cmd_q.wdata;
  assign Busy        = (state != ST_IDLE);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= ST_IDLE;
      tmo_cnt <= '0;
      armed   <= 1'b0;
      win_q   <= 1'b0;
      cmd_q   <= '0;
      Mem_Req <= 1'b0;
      Gnt0    <= 1'b0;
      Gnt1    <= 1'b0;
      Done0   <= 1'b0;
      Done1   <= 1'b0;
      Err     <= 1'b0;
    end else begin
      armed <= 1'b1;
      Gnt0  <= 1'b0;
      Gnt1  <= 1'b0;
      Done0 <= 1'b0;
      Done1 <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_en) begin
            state   <= ST_ISSUE;
            Mem_Req <= 1'b1;
            cmd_q   <= cmd_win;
            win_q   <= win1;
            Gnt0    <= !win1;
            Gnt1    <= win1;
            tmo_cnt <= '0;
          end
        end
        ST_ISSUE: begin
          if (Mem_Ack) begin
            state   <= ST_WAIT_DONE;
            Mem_Req <= 1'b0;
          end else if (tmo_cnt == TW'(ACK_TIMEOUT - 1)) begin
            // Counter would reach ACK_TIMEOUT on this edge: abandon, no Done.
            state   <= ST_IDLE;
            Mem_Req <= 1'b0;
            Err     <= 1'b1;
            tmo_cnt <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (!Mem_Busy) begin
            state <= ST_IDLE;
            Done0 <= !win_q;
            Done1 <= win_q;
          end
        end
        default: begin
          state   <= ST_IDLE;
          Mem_Req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed self-checking bench for sdram_arbiter.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: Mem_Busy/Mem_Ack are driven directly by the directed steps.
module tb_sdram_arbiter;
  import sdram_pkg::*;

  logic              Clk = 1'b0;
  logic              Reset_n;
  logic              Req0, Req1, WnR0, WnR1;
  logic [ADDR_W-1:0] Addr0, Addr1;
  logic [DATA_W-1:0] WData0, WData1;
  logic              Gnt0, Gnt1, Done0, Done1;
  logic              Mem_Req, Mem_WnR;
  logic [ADDR_W-1:0] Mem_Address;
  logic [DATA_W-1:0] Mem_WData;
  logic              Mem_Busy, Mem_Ack;
  logic              Busy, Err;

  int vectors     = 0;
  int miscompares = 0;

  always #5 Clk = ~Clk;

  sdram_arbiter #(
    .MAX_STREAK (8),
    .ACK_TIMEOUT(16)
  ) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .Req0       (Req0),
    .Req1       (Req1),
    .WnR0       (WnR0),
    .WnR1       (WnR1),
    .Addr0      (Addr0),
    .Addr1      (Addr1),
    .WData0     (WData0),
    .WData1     (WData1),
    .Gnt0       (Gnt0),
    .Gnt1       (Gnt1),
    .Done0      (Done0),
    .Done1      (Done1),
    .Mem_Req    (Mem_Req),
    .Mem_WnR    (Mem_WnR),
    .Mem_Address(Mem_Address),
    .Mem_WData  (Mem_WData),
    .Mem_Busy   (Mem_Busy),
    .Mem_Ack    (Mem_Ack),
    .Busy       (Busy),
    .Err        (Err)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  initial begin
    Reset_n  = 1'b1;
    Req0 = 1'b1; WnR0 = 1'b1; Addr0 = 22'h00_0010; WData0 = 16'hA5A5;
    Req1 = 1'b0; WnR1 = 1'b0; Addr1 = '0;          WData1 = '0;
    Mem_Busy = 1'b0; Mem_Ack = 1'b0;
    #1 Reset_n = 1'b0;
    #1;
    // Reset state
    check("rst_mem_req",  Mem_Req, 0);
    check("rst_gnt",      {Gnt1, Gnt0}, 0);
    check("rst_done",     {Done1, Done0}, 0);
    check("rst_busy_err", {Busy, Err}, 0);
    check("rst_addr",     Mem_Address, 0);
    check("rst_wdata",    {Mem_WnR, Mem_WData}, 0);

    // Release between edges: first edge only arms, second edge grants.
    #10 Reset_n = 1'b1;
    tick();
    check("arm_no_gnt", Gnt0, 0);
    check("arm_idle",   Busy, 0);
    tick();
    check("single_gnt0",  {Gnt1, Gnt0}, 2'b01);
    check("single_addr",  Mem_Address, 22'h00_0010);
    check("single_wdata", Mem_WData, 16'hA5A5);
    check("single_wnr",   Mem_WnR, 1);
    check("single_req",   Mem_Req, 1);
    // Requester lets go; later changes must not leak into the command.
    Req0 = 1'b0; Addr0 = 22'h3F_0000; WData0 = 16'h0000;
    tick();
    check("issue_hold_req", Mem_Req, 1);
    check("gnt_one_pulse",  Gnt0, 0);
    Mem_Ack = 1'b1;
    tick();
    check("wait_req_low", Mem_Req, 0);
    check("wait_busy",    Busy, 1);
    Mem_Ack = 1'b0; Mem_Busy = 1'b1;
    tick();
    check("wait_no_done", Done0, 0);
    check("wait_addr_stable", Mem_Address, 22'h00_0010);
    Mem_Busy = 1'b0;
    tick();
    check("single_done0", {Done1, Done0}, 2'b01);
    check("single_idle",  Busy, 0);
    tick();
    check("done_one_pulse", Done0, 0);

    // Simultaneous requests: port 0 first, port 1 after Done0.
    Req0 = 1'b1; WnR0 = 1'b1; Addr0 = 22'h00_0020; WData0 = 16'h1111;
    Req1 = 1'b1; WnR1 = 1'b0; Addr1 = 22'h2A_BCDE; WData1 = 16'h2222;
    tick();
    check("both_gnt0",  {Gnt1, Gnt0}, 2'b01);
    check("both_addr0", Mem_Address, 22'h00_0020);
    Req0 = 1'b0; Mem_Ack = 1'b1;
    tick();
    Mem_Ack = 1'b0;
    tick();
    check("both_done0",     {Done1, Done0}, 2'b01);
    check("both_no_gnt1_yet", Gnt1, 0);
    tick();
    check("both_gnt1",  {Gnt1, Gnt0}, 2'b10);
    check("both_addr1", Mem_Address, 22'h2A_BCDE);
    check("both_wnr1",  Mem_WnR, 0);
    Req1 = 1'b0; Mem_Ack = 1'b1;
    tick();
    Mem_Ack = 1'b0;
    tick();
    check("both_done1", {Done1, Done0}, 2'b10);

    // Streak limit: 8 port-0 grants, then port 1, then port 0 again.
    Req0 = 1'b1; Req1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("streak_gnt_%0d", i), {Gnt1, Gnt0}, (i == 8) ? 2'b10 : 2'b01);
      Mem_Ack = 1'b1;
      tick();
      Mem_Ack = 1'b0;
      tick();
    end
    Req0 = 1'b0; Req1 = 1'b0;
    tick();
    check("streak_idle", Busy, 0);

    // Mem_Busy holds off a port-1 request.
    Mem_Busy = 1'b1;
    Req1 = 1'b1; WnR1 = 1'b1; Addr1 = 22'h3F_FFFF; WData1 = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("memBusy_hold_%0d", i), {Busy, Gnt1}, 2'b00);
    end
    Mem_Busy = 1'b0;
    tick();
    check("memBusy_gnt1",  Gnt1, 1);
    check("memBusy_addr",  Mem_Address, 22'h3F_FFFF);
    check("memBusy_wdata", Mem_WData, 16'h1234);
    Req1 = 1'b0;

    // No Mem_Ack: 16 cycles in ISSUE, then Err and back to IDLE.
    repeat (15) tick();
    check("tmo_before_req", Mem_Req, 1);
    check("tmo_before_err", Err, 0);
    tick();
    check("tmo_err",     Err, 1);
    check("tmo_req_low", Mem_Req, 0);
    check("tmo_idle",    Busy, 0);
    check("tmo_no_done", {Done1, Done0}, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("tmo_sticky_%0d", i), {Err, Done1, Done0}, 3'b100);
    end

    // Reset while in WAIT_DONE: everything drops at once, no Done.
    Req0 = 1'b1; WnR0 = 1'b0; Addr0 = 22'h15_5555; WData0 = 16'hBEEF;
    tick();
    check("rst2_gnt0", Gnt0, 1);
    Req0 = 1'b0; Mem_Ack = 1'b1;
    tick();
    Mem_Ack = 1'b0; Mem_Busy = 1'b1;
    tick();
    check("rst2_in_wait", {Busy, Err}, 2'b11);
    check("rst2_addr",    Mem_Address, 22'h15_5555);
    #2 Reset_n = 1'b0;
    #1;
    check("rst2_busy",  Busy, 0);
    check("rst2_err",   Err, 0);
    check("rst2_req",   Mem_Req, 0);
    check("rst2_addr0", Mem_Address, 0);
    check("rst2_gdone", {Gnt1, Gnt0, Done1, Done0}, 0);
    Mem_Busy = 1'b0;
    #2 Reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("rst2_no_done_%0d", i), {Done1, Done0, Busy, Err}, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
